// File: rtl/er_exec_tracker_if.sv
// Handshake bundle between the ER pass tracker and its driver / attestation reader.
interface er_exec_tracker_if #(
  parameter int CNT_W = 8
);
  logic [15:0]      pc;
  logic             irq;
  logic             exec;
  logic [15:0]      ER_min;
  logic [15:0]      ER_max;
  logic             clr;
  logic             er_active;
  logic             exec_done;
  logic [1:0]       abort_cause;
  logic [CNT_W-1:0] run_count;

  modport master (
    output pc, irq, exec, ER_min, ER_max, clr,
    input  er_active, exec_done, abort_cause, run_count
  );

  modport slave (
    input  pc, irq, exec, ER_min, ER_max, clr,
    output er_active, exec_done, abort_cause, run_count
  );
endinterface

// File: rtl/er_exec_tracker.sv
// Tracks one complete pass through the executable region and publishes a sticky
// completion proof, a failure cause and a saturating count of clean passes.
module er_exec_tracker #(
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  er_exec_tracker_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2,
    ST_FAIL = 2'd3
  } state_e;

  localparam logic [1:0]       CAUSE_NONE      = 2'b00;
  localparam logic [1:0]       CAUSE_EXEC_LOST = 2'b01;
  localparam logic [1:0]       CAUSE_IRQ       = 2'b10;
  localparam logic [1:0]       CAUSE_ESCAPE    = 2'b11;
  localparam logic [CNT_W-1:0] CNT_MAX         = '1;

  state_e           state_q, state_d;
  logic             done_q,  done_d;
  logic [1:0]       cause_q, cause_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic in_er;
  logic at_entry;
  logic at_exit;

  assign in_er    = (bus.pc >= bus.ER_min) && (bus.pc <= bus.ER_max);
  assign at_entry = (bus.pc == bus.ER_min);
  assign at_exit  = (bus.pc == bus.ER_max);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      done_q  <= 1'b0;
      cause_q <= CAUSE_NONE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      cause_q <= cause_d;
      count_q <= count_d;
    end
  end

  // clr outranks every state rule but deliberately leaves the run counter alone.
  always_comb begin
    state_d = state_q;
    done_d  = done_q;
    cause_d = cause_q;
    count_d = count_q;
    if (bus.clr) begin
      state_d = ST_IDLE;
      done_d  = 1'b0;
      cause_d = CAUSE_NONE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (at_entry) begin
            state_d = ST_RUN;
          end
        end
        ST_RUN: begin
          if (!bus.exec) begin
            state_d = ST_FAIL;
            cause_d = CAUSE_EXEC_LOST;
          end else if (bus.irq) begin
            state_d = ST_FAIL;
            cause_d = CAUSE_IRQ;
          end else if (!in_er) begin
            state_d = ST_FAIL;
            cause_d = CAUSE_ESCAPE;
          end else if (at_exit) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            if (count_q != CNT_MAX) begin
              count_d = count_q + 1'b1;
            end
          end
        end
        ST_DONE: begin
          // Losing exec after completion means the proof no longer holds.
          if (!bus.exec) begin
            state_d = ST_IDLE;
            done_d  = 1'b0;
          end else if (at_entry) begin
            state_d = ST_RUN;
            done_d  = 1'b0;
          end
        end
        ST_FAIL: begin
          if (at_entry) begin
            state_d = ST_RUN;
            cause_d = CAUSE_NONE;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    bus.er_active   = (state_q == ST_RUN);
    bus.exec_done   = done_q;
    bus.abort_cause = cause_q;
    bus.run_count   = count_q;
  end

  a_cause_only_in_fail: assert property (@(posedge clk) disable iff (reset)
    (cause_q != CAUSE_NONE) == (state_q == ST_FAIL));

  a_done_only_in_done: assert property (@(posedge clk) disable iff (reset)
    done_q == (state_q == ST_DONE));

endmodule

// File: tb/tb_er_exec_tracker.sv
// Self-checking bench: directed table, hand-written corner sequences, random vs pass-level model.
module tb_er_exec_tracker;
  localparam int CNT_W = 2;
  localparam int CMAX  = 3;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  er_exec_tracker_if #(.CNT_W(CNT_W)) bus_if ();
  er_exec_tracker #(.CNT_W(CNT_W)) dut (.clk(clk), .reset(reset), .bus(bus_if));

  int tests = 0;
  int fails = 0;

  // Pass-level model: inside a pass, holding a proof, holding a cause, or none of these.
  bit m_pass;
  bit m_proof;
  int m_cause;
  int m_runs;

  typedef struct {
    logic [15:0] pc;
    bit          irq;
    bit          exec;
    bit          clr;
    logic [5:0]  exp;
  } vec_t;
  vec_t tbl[$];

  function automatic logic [5:0] enc(bit a, bit d, int c, int n);
    logic [1:0] cc;
    logic [1:0] nn;
    cc = c[1:0];
    nn = n[1:0];
    return {a, d, cc, nn};
  endfunction

  function automatic vec_t mk(logic [15:0] pc, bit irq, bit exec, bit clr, logic [5:0] exp);
    vec_t v;
    v.pc = pc; v.irq = irq; v.exec = exec; v.clr = clr; v.exp = exp;
    return v;
  endfunction

  function automatic logic [5:0] mexp();
    return enc(m_pass, m_proof, m_cause, m_runs);
  endfunction

  task automatic model_reset();
    m_pass = 0; m_proof = 0; m_cause = 0; m_runs = 0;
  endtask

  task automatic model_step(logic [15:0] pc, bit irq, bit exec, bit clr);
    bit inside_er;
    inside_er = (pc >= bus_if.ER_min) && (pc <= bus_if.ER_max);
    if (clr) begin
      m_pass = 0; m_proof = 0; m_cause = 0;
    end else if (m_pass) begin
      if (!exec)           begin m_pass = 0; m_cause = 1; end
      else if (irq)        begin m_pass = 0; m_cause = 2; end
      else if (!inside_er) begin m_pass = 0; m_cause = 3; end
      else if (pc == bus_if.ER_max) begin
        m_pass  = 0;
        m_proof = 1;
        m_runs  = (m_runs < CMAX) ? m_runs + 1 : CMAX;
      end
    end else if (m_proof) begin
      if (!exec) m_proof = 0;
      else if (pc == bus_if.ER_min) begin m_proof = 0; m_pass = 1; end
    end else if (m_cause != 0) begin
      if (pc == bus_if.ER_min) begin m_cause = 0; m_pass = 1; end
    end else if (pc == bus_if.ER_min) begin
      m_pass = 1;
    end
  endtask

  task automatic chk(string name, logic [5:0] exp);
    logic [5:0] got;
    got = {bus_if.er_active, bus_if.exec_done, bus_if.abort_cause, bus_if.run_count};
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got act=%0d done=%0d cause=%0d cnt=%0d, expected act=%0d done=%0d cause=%0d cnt=%0d",
               name, got[5], got[4], got[3:2], got[1:0], exp[5], exp[4], exp[3:2], exp[1:0]);
    end
  endtask

  // Inputs change 1 time unit after the edge; outputs are sampled 1 unit after the next edge.
  task automatic step(logic [15:0] pc, bit irq, bit exec, bit clr);
    bus_if.pc = pc; bus_if.irq = irq; bus_if.exec = exec; bus_if.clr = clr;
    @(posedge clk);
    model_step(pc, irq, exec, clr);
    #1;
  endtask

  task automatic step_chk(string name, logic [15:0] pc, bit irq, bit exec, bit clr);
    step(pc, irq, exec, clr);
    chk(name, mexp());
  endtask

  task automatic do_reset(logic [15:0] mn, logic [15:0] mx);
    bus_if.pc = 16'h0; bus_if.irq = 0; bus_if.exec = 0; bus_if.clr = 0;
    bus_if.ER_min = mn; bus_if.ER_max = mx;
    reset = 1'b1;
    #1;
    chk("reset_state", enc(0, 0, 0, 0));
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Enters at `from` with exec low, then walks to `to` with exec high, checking every cycle.
  task automatic walk(string name, logic [15:0] from, logic [15:0] to);
    step_chk(name, from, 0, 0, 0);
    for (int p = int'(from) + 1; p <= int'(to); p++) step_chk(name, 16'(p), 0, 1, 0);
  endtask

  initial begin
    bus_if.pc = 0; bus_if.irq = 0; bus_if.exec = 0; bus_if.clr = 0;
    bus_if.ER_min = 0; bus_if.ER_max = 0;

    // Directed table on a short region 0100..0103 with CNT_W=2.
    tbl.push_back(mk(16'h0050, 0, 0, 0, enc(0, 0, 0, 0)));
    tbl.push_back(mk(16'h0100, 0, 0, 0, enc(1, 0, 0, 0)));
    tbl.push_back(mk(16'h0101, 0, 1, 0, enc(1, 0, 0, 0)));
    tbl.push_back(mk(16'h0102, 0, 1, 0, enc(1, 0, 0, 0)));
    tbl.push_back(mk(16'h0103, 0, 1, 0, enc(0, 1, 0, 1)));
    tbl.push_back(mk(16'h0103, 0, 1, 0, enc(0, 1, 0, 1)));
    tbl.push_back(mk(16'h0100, 0, 1, 0, enc(1, 0, 0, 1)));
    tbl.push_back(mk(16'h0101, 1, 1, 0, enc(0, 0, 2, 1)));
    tbl.push_back(mk(16'h0103, 0, 1, 0, enc(0, 0, 2, 1)));
    tbl.push_back(mk(16'h0100, 0, 1, 0, enc(1, 0, 0, 1)));
    tbl.push_back(mk(16'h0101, 0, 1, 0, enc(1, 0, 0, 1)));
    tbl.push_back(mk(16'h0103, 1, 1, 0, enc(0, 0, 2, 1)));
    tbl.push_back(mk(16'h0100, 0, 1, 0, enc(1, 0, 0, 1)));
    tbl.push_back(mk(16'h0200, 0, 1, 0, enc(0, 0, 3, 1)));
    tbl.push_back(mk(16'h0100, 0, 1, 0, enc(1, 0, 0, 1)));
    tbl.push_back(mk(16'h0101, 0, 0, 0, enc(0, 0, 1, 1)));
    tbl.push_back(mk(16'h0050, 0, 1, 1, enc(0, 0, 0, 1)));
    tbl.push_back(mk(16'h0100, 0, 1, 0, enc(1, 0, 0, 1)));
    tbl.push_back(mk(16'h0103, 0, 1, 0, enc(0, 1, 0, 2)));
    tbl.push_back(mk(16'h0100, 0, 0, 0, enc(0, 0, 0, 2)));
    tbl.push_back(mk(16'h0100, 0, 1, 0, enc(1, 0, 0, 2)));
    tbl.push_back(mk(16'h0103, 0, 1, 0, enc(0, 1, 0, 3)));
    tbl.push_back(mk(16'h0100, 0, 1, 0, enc(1, 0, 0, 3)));
    tbl.push_back(mk(16'h0103, 0, 1, 0, enc(0, 1, 0, 3)));
    tbl.push_back(mk(16'h0050, 0, 1, 1, enc(0, 0, 0, 3)));
    tbl.push_back(mk(16'h0100, 0, 1, 1, enc(0, 0, 0, 3)));
    tbl.push_back(mk(16'h00FF, 0, 1, 0, enc(0, 0, 0, 3)));

    do_reset(16'h0100, 16'h0103);
    foreach (tbl[i]) begin
      step(tbl[i].pc, tbl[i].irq, tbl[i].exec, tbl[i].clr);
      chk($sformatf("tbl[%0d]", i), tbl[i].exp);
    end

    // Async reset between edges mid-RUN clears everything, including the counter.
    step(16'h0100, 0, 1, 0);
    chk("pre_async_run", enc(1, 0, 0, 3));
    #2;
    reset = 1'b1;
    #1;
    chk("async_reset", enc(0, 0, 0, 0));
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Clean full walk.
    do_reset(16'hE000, 16'hE0FE);
    walk("clean_walk", 16'hE000, 16'hE0FD);
    step(16'hE0FE, 0, 1, 0);
    chk("clean_done", enc(0, 1, 0, 1));

    // Irq abort at E040, then re-entry clears the cause.
    do_reset(16'hE000, 16'hE0FE);
    walk("irq_walk", 16'hE000, 16'hE03F);
    step(16'hE040, 1, 1, 0);
    chk("irq_abort", enc(0, 0, 2, 0));
    step(16'hE041, 0, 1, 0);
    chk("irq_sticky", enc(0, 0, 2, 0));
    step(16'hE000, 0, 1, 0);
    chk("irq_reentry", enc(1, 0, 0, 0));

    // Escape from E020 to C000; a later ER_max must not set the proof.
    do_reset(16'hE000, 16'hE0FE);
    walk("esc_walk", 16'hE000, 16'hE020);
    step(16'hC000, 0, 1, 0);
    chk("escape", enc(0, 0, 3, 0));
    step(16'hE0FE, 0, 1, 0);
    chk("escape_no_done", enc(0, 0, 3, 0));

    // Exec loss mid-pass, then exec loss while holding a proof.
    do_reset(16'hE000, 16'hE0FE);
    walk("exec_walk", 16'hE000, 16'hE00F);
    step(16'hE010, 0, 0, 0);
    chk("exec_lost", enc(0, 0, 1, 0));
    walk("exec_rewalk", 16'hE000, 16'hE0FE);
    chk("exec_done_set", enc(0, 1, 0, 1));
    step(16'h1234, 0, 0, 0);
    chk("done_exec_drop", enc(0, 0, 0, 1));

    // Saturation over five passes, then clr in DONE.
    do_reset(16'h0100, 16'h0103);
    for (int r = 0; r < 5; r++) walk("sat_walk", 16'h0100, 16'h0103);
    chk("saturated", enc(0, 1, 0, 3));
    step(16'h0050, 0, 1, 1);
    chk("clr_in_done", enc(0, 0, 0, 3));

    // Degenerate single-address region.
    do_reset(16'h0300, 16'h0300);
    step(16'h0300, 0, 0, 0);
    chk("degen_enter", enc(1, 0, 0, 0));
    step(16'h0300, 0, 1, 0);
    chk("degen_done", enc(0, 1, 0, 1));

    // Randomized traffic against the model.
    do_reset(16'h1000, 16'h1003);
    for (int n = 0; n < 4000; n++) begin
      logic [15:0] p;
      int r;
      if (n % 200 == 0) begin
        bus_if.ER_min = 16'h1000 + 16'($urandom_range(0, 3));
        bus_if.ER_max = bus_if.ER_min + 16'($urandom_range(0, 5));
      end
      r = int'($urandom_range(0, 9));
      if (r <= 2)      p = bus_if.ER_min;
      else if (r == 3) p = bus_if.ER_max;
      else if (r <= 7) p = bus_if.ER_min + 16'($urandom_range(0, int'(bus_if.ER_max - bus_if.ER_min)));
      else if (r == 8) p = bus_if.ER_min - 16'd1;
      else             p = bus_if.ER_max + 16'd1;
      step_chk("random", p, $urandom_range(0, 29) == 0, $urandom_range(0, 19) != 0,
               $urandom_range(0, 49) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/er_exec_tracker.md
Name: er_exec_tracker

Overview:
- Sits directly downstream of the executable-region boundary monitor and consumes its registered `exec` flag.
- Tracks one complete pass through the executable region (ER), from entry at ER_min to exit at ER_max.
- Publishes a sticky `exec_done` proof bit, a cause code on failure, and a saturating count of successful runs.
- Outputs feed the metadata/attestation logic read by the verifier.

Parameters:
- CNT_W, 8, width of run_count; the counter saturates at 2^CNT_W-1.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- pc  input  16  current program counter.
- irq  input  1  interrupt taken this cycle.
- exec  input  1  registered execution-valid flag from the boundary monitor.
- ER_min  input  16  first ER instruction address.
- ER_max  input  16  last ER instruction address (legal exit point).
- clr  input  1  software/metadata clear pulse.
- er_active  output  1  high while in state RUN.
- exec_done  output  1  sticky: last ER pass completed cleanly.
- abort_cause  output  2  00 none, 01 exec lost, 10 irq in ER, 11 pc escaped ER.
- run_count  output  CNT_W  number of successful completions, saturating.

Behaviour:
- All outputs are registered; none is combinational from inputs.
- On reset assertion: state=IDLE, er_active=0, exec_done=0, abort_cause=00, run_count=0. Reset takes effect immediately, with no clock required.
- States: IDLE, RUN, DONE, FAIL (2-bit encoding).
- `in_er` is defined as (pc >= ER_min && pc <= ER_max).
- `clr` has the highest priority in every state.
  - Next state is IDLE; exec_done<=0; abort_cause<=00.
  - run_count is unchanged; only reset clears it.
- IDLE:
  - pc==ER_min -> RUN.
  - Otherwise stay in IDLE.
- RUN: evaluated in the priority order below, the first match wins.
  1. exec==0 -> FAIL, cause 01. exec is sampled from the cycle after entry; the monitor raises exec one cycle after pc==ER_min, which aligns with the RUN entry.
  2. irq==1 -> FAIL, cause 10.
  3. !in_er -> FAIL, cause 11.
  4. pc==ER_max -> DONE; exec_done<=1; run_count<=run_count+1 unless already all-ones.
  5. Otherwise stay in RUN.
- DONE:
  - exec==0 (metadata modified after completion) -> IDLE, exec_done<=0.
  - Else pc==ER_min -> RUN, exec_done<=0 (a new pass invalidates the old proof).
  - Otherwise hold.
- FAIL:
  - pc==ER_min -> RUN, abort_cause<=00.
  - Otherwise hold; abort_cause stays sticky.
- er_active=1 exactly when the registered state is RUN.
- exec_done is set only on the RUN->DONE transition, and is visible the cycle after pc==ER_max is sampled.
- Degenerate ER (ER_min==ER_max):
  - IDLE->RUN on pc==ER_min.
  - Next cycle: if pc still equals ER_max and exec==1 -> DONE.
- Simultaneous irq and pc==ER_max in RUN: irq wins, giving FAIL with cause 10.
- Reset asserted mid-RUN: immediate return to IDLE with all outputs cleared, including run_count.

Test Plan:
- Clean run: ER_min=E000, ER_max=E0FE; pc walks E000..E0FE with exec high from the 2nd cycle -> exec_done=1 one cycle after pc=E0FE; run_count=1; abort_cause=00.
- Irq abort: same walk with irq=1 at pc=E040 -> FAIL, abort_cause=10, exec_done=0, run_count=0; re-entry at E000 clears cause to 00.
- Escape: pc jumps from E020 to C000 -> abort_cause=11, er_active falls next cycle; pc=ER_max later does not set exec_done.
- Exec loss: exec drops at pc=E010 -> abort_cause=01. In DONE, dropping exec clears exec_done to 0 and returns to IDLE.
- Saturation and clear: CNT_W=2, five clean runs -> run_count=3; clr pulse in DONE -> exec_done=0, run_count stays 3.
- Async reset: assert reset between clock edges mid-RUN -> all outputs 0 immediately; priority check with irq=1 and pc=ER_max in the same cycle -> cause 10.
